cache_arbiter: RTL and testbench
================================

Name: cache_arbiter

Overview:
- Registered arbiter between the split L1 caches (instruction and data) and the shared L2 cache.
- Replaces the combinational I-priority mux in the mp4 top level.
- Locks a grant for the full duration of one L2 transaction, so a newly arriving I-fetch cannot redirect an in-flight D write-back or fill.
- Captures request address and data at grant. Routes the L2 response only to the granted cache.

Parameters:
- ADDR_W, 32, address width on all ports.
- LINE_W, 256, cacheline width on all ports.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- i_pmem_read  input  1  icache line read request.
- i_pmem_write  input  1  icache line write request; tied 0 in current top, still arbitrated.
- i_pmem_address  input  ADDR_W  icache line address.
- i_pmem_wdata  input  LINE_W  icache write line.
- i_pmem_rdata  output  LINE_W  line returned to icache.
- i_pmem_resp  output  1  transaction done, icache.
- d_pmem_read  input  1  dcache line read request.
- d_pmem_write  input  1  dcache line write request.
- d_pmem_address  input  ADDR_W  dcache line address.
- d_pmem_wdata  input  LINE_W  dcache write line.
- d_pmem_rdata  output  LINE_W  line returned to dcache.
- d_pmem_resp  output  1  transaction done, dcache.
- ab_pmem_read  output  1  read request to L2.
- ab_pmem_write  output  1  write request to L2.
- ab_pmem_address  output  ADDR_W  address to L2.
- ab_pmem_wdata  output  LINE_W  write line to L2.
- ab_pmem_rdata  input  LINE_W  line from L2.
- ab_pmem_resp  input  1  L2 transaction done.

Behaviour:
- Clock and reset: one clock domain, clk. Reset is synchronous and active-high on reset.
- States: IDLE, I_BUSY, D_BUSY.
- Reset: state goes to IDLE. The address, wdata and op registers clear to 0. The last_grant register is set to D.
- Outputs during and after reset: all ab_pmem_* outputs are 0. i_/d_pmem_resp are 0. Both rdata outputs are 0.
- A request is pending on a side when its read or write input is 1.

IDLE:
- No pending request: stay in IDLE.
- Pending request(s): pick a winner by the grant policy.
- On the grant edge, register the winner's address, wdata, read and write.
- Move to I_BUSY or D_BUSY.
- All outputs are 0 while in IDLE.

I_BUSY / D_BUSY:
- ab_pmem_read, ab_pmem_write, ab_pmem_address and ab_pmem_wdata are driven from the captured registers.
- Input changes after grant are ignored.
- The granted side's rdata is driven combinationally from ab_pmem_rdata.
- The granted side's resp equals ab_pmem_resp.
- The non-granted side sees rdata = 0 and resp = 0, always.
- When ab_pmem_resp = 1, go to IDLE and update last_grant.
- The captured registers are not cleared, but ab_pmem_read and ab_pmem_write are forced to 0 in IDLE.

Latency:
- One cycle of arbitration: request seen at edge N, ab_pmem_read or ab_pmem_write is high after edge N+1.
- Response pass-through has 0 added cycles.
- Back-to-back: the cycle after a resp is spent in IDLE. The next grant takes effect one edge later.
- The IDLE bubble guarantees the completing cache has dropped its request before re-arbitration. No double service.

Boundary conditions:
- Read and write both high on one side: read wins. The write flag is not captured.
- ab_pmem_resp while in IDLE: ignored, nothing forwarded.
- Reset mid-transaction: state goes to IDLE immediately and no resp is forwarded. L2 is reset on the same reset and drops the transaction.
- A request dropped before grant: not captured if already low at the sampling edge.

Grant policy (default):
- Fixed priority, I over D, when both are pending in IDLE.
- Starvation of D is bounded only by icache miss rate.

Optional Feature:
Macro: ARB_ROUND_ROBIN_EN.
- Defined: when both sides are pending in IDLE, grant the side opposite last_grant. A single pending side is always granted. last_grant is updated on each completed transaction.
- Undefined: fixed I-over-D priority. last_grant is still maintained but unused.

Test Plan:
1. Reset, then I read 0x0000_1000 alone -> ab_pmem_read = 1 with address 0x0000_1000 one cycle later. L2 resp with rdata 0xAA..AA -> i_pmem_resp = 1 and i_pmem_rdata = 0xAA..AA in the same cycle. d_pmem_resp = 0 throughout.
2. D write 0x0000_2040 granted, then I read rises 2 cycles later -> ab_pmem_write stays 1 with address 0x0000_2040 until resp. After d_pmem_resp, one IDLE cycle, then ab_pmem_read with the I address.
3. I and D both request in the same cycle -> I is granted first. With ARB_ROUND_ROBIN_EN and last_grant = I, D is granted first instead.
4. D address changes from 0x0000_3000 to 0x0000_3020 after grant -> ab_pmem_address stays 0x0000_3000 until resp.
5. reset asserted 3 cycles into an I_BUSY transaction -> all outputs 0 on the next edge. A stray ab_pmem_resp afterwards produces no i_/d_pmem_resp.
6. D read and write both high -> only ab_pmem_read = 1, ab_pmem_write = 0.

Source files
------------

// File: rtl/cache_arbiter.sv
// Registered L1I/L1D -> L2 arbiter; one-cycle grant, transaction locked until ab_pmem_resp, zero-cycle response path.
// Fixed I-over-D priority by default; define ARB_ROUND_ROBIN_EN to alternate grants when both sides contend.
module cache_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_pmem_read,
  input  logic              i_pmem_write,
  input  logic [ADDR_W-1:0] i_pmem_address,
  input  logic [LINE_W-1:0] i_pmem_wdata,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              ab_pmem_read,
  output logic              ab_pmem_write,
  output logic [ADDR_W-1:0] ab_pmem_address,
  output logic [LINE_W-1:0] ab_pmem_wdata,
  input  logic [LINE_W-1:0] ab_pmem_rdata,
  input  logic              ab_pmem_resp
);

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] I_BUSY = 2'b01;
  localparam logic [1:0] D_BUSY = 2'b10;

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  logic [1:0]        state;
  logic              last_grant_d;  // 1: last completed transaction belonged to D
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              read_q;
  logic              write_q;

  logic i_pend;
  logic d_pend;
  logic grant_d;
  logic busy;
  logic i_sel;
  logic d_sel;

  assign i_pend = i_pmem_read | i_pmem_write;
  assign d_pend = d_pmem_read | d_pmem_write;

  // D wins when alone, or under round-robin when I held the previous grant.
  assign grant_d = d_pend & (~i_pend | (RR_EN & ~last_grant_d));

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      last_grant_d <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            addr_q  <= d_pmem_address;
            wdata_q <= d_pmem_wdata;
            read_q  <= d_pmem_read;
            write_q <= d_pmem_write & ~d_pmem_read;
            state   <= D_BUSY;
          end else if (i_pend) begin
            addr_q  <= i_pmem_address;
            wdata_q <= i_pmem_wdata;
            read_q  <= i_pmem_read;
            write_q <= i_pmem_write & ~i_pmem_read;
            state   <= I_BUSY;
          end
        end
        I_BUSY, D_BUSY: begin
          if (ab_pmem_resp) begin
            state        <= IDLE;
            last_grant_d <= (state == D_BUSY);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign i_sel = (state == I_BUSY);
  assign d_sel = (state == D_BUSY);
  assign busy  = i_sel | d_sel;

  assign ab_pmem_read    = busy & read_q;
  assign ab_pmem_write   = busy & write_q;
  assign ab_pmem_address = busy ? addr_q : '0;
  assign ab_pmem_wdata   = busy ? wdata_q : '0;

  assign i_pmem_rdata = i_sel ? ab_pmem_rdata : '0;
  assign i_pmem_resp  = i_sel & ab_pmem_resp;
  assign d_pmem_rdata = d_sel ? ab_pmem_rdata : '0;
  assign d_pmem_resp  = d_sel & ab_pmem_resp;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter; expectations follow ARB_ROUND_ROBIN_EN when it is defined.
module tb_cache_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_pmem_read, i_pmem_write, d_pmem_read, d_pmem_write;
  logic [AW-1:0] i_pmem_address, d_pmem_address;
  logic [LW-1:0] i_pmem_wdata, d_pmem_wdata;
  logic [LW-1:0] i_pmem_rdata, d_pmem_rdata;
  logic          i_pmem_resp, d_pmem_resp;
  logic          ab_pmem_read, ab_pmem_write;
  logic [AW-1:0] ab_pmem_address;
  logic [LW-1:0] ab_pmem_wdata;
  logic [LW-1:0] ab_pmem_rdata;
  logic          ab_pmem_resp;

  int checks = 0;
  int passed = 0;

  logic [LW-1:0] line_aa, line_bb, line_w1;
  logic [AW-1:0] first_addr, second_addr;
  logic          first_is_d;

  cache_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .reset(reset),
    .i_pmem_read(i_pmem_read), .i_pmem_write(i_pmem_write),
    .i_pmem_address(i_pmem_address), .i_pmem_wdata(i_pmem_wdata),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .ab_pmem_read(ab_pmem_read), .ab_pmem_write(ab_pmem_write),
    .ab_pmem_address(ab_pmem_address), .ab_pmem_wdata(ab_pmem_wdata),
    .ab_pmem_rdata(ab_pmem_rdata), .ab_pmem_resp(ab_pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".ab_read"}, LW'(ab_pmem_read), '0);
    check({tag, ".ab_write"}, LW'(ab_pmem_write), '0);
    check({tag, ".ab_addr"}, LW'(ab_pmem_address), '0);
    check({tag, ".ab_wdata"}, ab_pmem_wdata, '0);
    check({tag, ".i_resp"}, LW'(i_pmem_resp), '0);
    check({tag, ".d_resp"}, LW'(d_pmem_resp), '0);
    check({tag, ".i_rdata"}, i_pmem_rdata, '0);
    check({tag, ".d_rdata"}, d_pmem_rdata, '0);
  endtask

  initial begin
    line_aa = {32{8'hAA}};
    line_bb = {32{8'hBB}};
    line_w1 = {8{32'h1234_5678}};
    reset = 1'b1;
    i_pmem_read = 0; i_pmem_write = 0; i_pmem_address = '0; i_pmem_wdata = '0;
    d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
    ab_pmem_rdata = '0; ab_pmem_resp = 0;
    tick; tick;
    check_quiet("reset");
    reset = 1'b0;

    // 1: lone I read
    i_pmem_read = 1; i_pmem_address = 32'h0000_1000;
    tick;
    check("t1.ab_read", LW'(ab_pmem_read), 1);
    check("t1.ab_write", LW'(ab_pmem_write), 0);
    check("t1.ab_addr", LW'(ab_pmem_address), LW'(32'h0000_1000));
    ab_pmem_rdata = line_aa; ab_pmem_resp = 1;
    #1;
    check("t1.i_resp", LW'(i_pmem_resp), 1);
    check("t1.i_rdata", i_pmem_rdata, line_aa);
    check("t1.d_resp", LW'(d_pmem_resp), 0);
    check("t1.d_rdata", d_pmem_rdata, '0);
    tick;
    ab_pmem_resp = 0; i_pmem_read = 0;
    #1;
    check("t1.idle_i_rdata", i_pmem_rdata, '0);
    check_quiet("t1.idle");

    // 2: D write-back locked against a later I read
    d_pmem_write = 1; d_pmem_address = 32'h0000_2040; d_pmem_wdata = line_w1;
    tick;
    check("t2.ab_write", LW'(ab_pmem_write), 1);
    check("t2.ab_wdata", ab_pmem_wdata, line_w1);
    tick; tick;
    i_pmem_read = 1; i_pmem_address = 32'h0000_1100;
    tick;
    check("t2.hold_write", LW'(ab_pmem_write), 1);
    check("t2.hold_read", LW'(ab_pmem_read), 0);
    check("t2.hold_addr", LW'(ab_pmem_address), LW'(32'h0000_2040));
    ab_pmem_resp = 1;
    #1;
    check("t2.d_resp", LW'(d_pmem_resp), 1);
    check("t2.i_resp", LW'(i_pmem_resp), 0);
    tick;
    ab_pmem_resp = 0; d_pmem_write = 0;
    #1;
    check("t2.bubble_read", LW'(ab_pmem_read), 0);
    check("t2.bubble_write", LW'(ab_pmem_write), 0);
    tick;
    check("t2.i_read", LW'(ab_pmem_read), 1);
    check("t2.i_addr", LW'(ab_pmem_address), LW'(32'h0000_1100));
    ab_pmem_resp = 1;
    tick;
    ab_pmem_resp = 0; i_pmem_read = 0;

    // 3: simultaneous requests; last grant was I
`ifdef ARB_ROUND_ROBIN_EN
    first_is_d = 1'b1; first_addr = 32'h0000_1300; second_addr = 32'h0000_1200;
`else
    first_is_d = 1'b0; first_addr = 32'h0000_1200; second_addr = 32'h0000_1300;
`endif
    i_pmem_read = 1; i_pmem_address = 32'h0000_1200;
    d_pmem_read = 1; d_pmem_address = 32'h0000_1300;
    tick;
    check("t3.first_addr", LW'(ab_pmem_address), LW'(first_addr));
    ab_pmem_rdata = line_bb; ab_pmem_resp = 1;
    #1;
    check("t3.first_d_resp", LW'(d_pmem_resp), LW'(first_is_d));
    check("t3.first_i_resp", LW'(i_pmem_resp), LW'(!first_is_d));
    tick;
    ab_pmem_resp = 0;
    if (first_is_d) d_pmem_read = 0; else i_pmem_read = 0;
    tick;
    check("t3.second_addr", LW'(ab_pmem_address), LW'(second_addr));
    ab_pmem_resp = 1;
    #1;
    check("t3.second_d_resp", LW'(d_pmem_resp), LW'(!first_is_d));
    check("t3.second_d_rdata", d_pmem_rdata, first_is_d ? '0 : line_bb);
    tick;
    ab_pmem_resp = 0; i_pmem_read = 0; d_pmem_read = 0;

    // 4: D address change after grant is ignored
    d_pmem_read = 1; d_pmem_address = 32'h0000_3000;
    tick;
    d_pmem_address = 32'h0000_3020;
    tick; tick;
    check("t4.addr_held", LW'(ab_pmem_address), LW'(32'h0000_3000));
    ab_pmem_resp = 1;
    tick;
    ab_pmem_resp = 0; d_pmem_read = 0;

    // 5: reset mid I transaction, then stray L2 resp
    i_pmem_read = 1; i_pmem_address = 32'h0000_4000;
    tick;
    tick; tick;
    check("t5.busy_read", LW'(ab_pmem_read), 1);
    reset = 1;
    tick;
    check_quiet("t5.reset");
    reset = 0; i_pmem_read = 0;
    ab_pmem_resp = 1;
    #1;
    check("t5.stray_i_resp", LW'(i_pmem_resp), 0);
    check("t5.stray_d_resp", LW'(d_pmem_resp), 0);
    tick;
    ab_pmem_resp = 0;
    #1;
    check_quiet("t5.after");

    // 6: read and write both high on D
    d_pmem_read = 1; d_pmem_write = 1; d_pmem_address = 32'h0000_5000;
    tick;
    check("t6.ab_read", LW'(ab_pmem_read), 1);
    check("t6.ab_write", LW'(ab_pmem_write), 0);
    ab_pmem_resp = 1;
    tick;
    ab_pmem_resp = 0; d_pmem_read = 0; d_pmem_write = 0;
    tick;
    check_quiet("t6.done");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
